// File: rtl/pixel_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_mixer_pkg
// Description : Shared PPU definitions used by the pixel mixer.
//               - C_X_MAX   : default visible pixels per scanline
//               - state_t   : mixer FSM state encoding (IDLE/DISCARD/PUSH/DONE)
//               - pal_shade : 8-bit palette + 2-bit colour index -> 2-bit shade
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_mixer_pkg;

    localparam int unsigned C_X_MAX = 160;

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE    = 2'd0;
    localparam state_t C_ST_DISCARD = 2'd1;
    localparam state_t C_ST_PUSH    = 2'd2;
    localparam state_t C_ST_DONE    = 2'd3;

    // A DMG-style palette packs four 2-bit shades; index n selects bits [2n+1:2n].
    function automatic logic [1:0] pal_shade(input logic [7:0] pal, input logic [1:0] idx);
        pal_shade = pal[{idx, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_mixer_palette_lookup.sv
`default_nettype none
// ============================================================================
// Module      : palette_lookup
// Description : Combinational palette lookup for the pixel output path.
//   i_palette  [7:0]  palette register (BGP, OBP0 or OBP1)
//   i_idx      [1:0]  colour index
//   o_shade    [1:0]  resulting shade
// Revision    : 1.0 - initial release
// ============================================================================
module palette_lookup
    import pixel_mixer_pkg::*;
(
    input  logic [7:0] i_palette,
    input  logic [1:0] i_idx,
    output logic [1:0] o_shade
);

    assign o_shade = pal_shade(i_palette, i_idx);

endmodule
`default_nettype wire

// File: rtl/pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_mixer
// Description : Pops background/sprite FIFOs once per T-cycle, discards the
//               SCX fine-scroll pixels, mixes background and sprite pixels,
//               maps the result through the selected palette and emits one
//               shade per accepted pop until X_MAX pixels have been sent.
// Ports       :
//   clk_in, rst_in (async, active-high), tclk_in (T-cycle enable)
//   start_in                  mode-3 start pulse (restarts the line anywhere)
//   SCX_in, BGP_in, OBP0_in, OBP1_in, bg_ena_in, obj_ena_in   PPU registers
//   sprite_hit_in             stalls popping while a sprite fetch runs
//   bg_rd_en_out/spr_rd_en_out  FIFO pop requests (identical)
//   bg_pixel_in/bg_valid_in   background pixel, one clk after the pop
//   spr_pixel_in/spr_palette_in/spr_priority_in/spr_valid_in  sprite pixel
//   pixel_out/pixel_valid_out shade to the LCD, one clk after bg_valid_in
//   X_out                     index of the next pixel to emit
//   line_done_out             one-clk pulse after the last pixel
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_mixer
    import pixel_mixer_pkg::*;
#(
    parameter int X_MAX = C_X_MAX
)(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tclk_in,
    input  logic       start_in,
    input  logic [7:0] SCX_in,
    input  logic [7:0] BGP_in,
    input  logic [7:0] OBP0_in,
    input  logic [7:0] OBP1_in,
    input  logic       bg_ena_in,
    input  logic       obj_ena_in,
    input  logic       sprite_hit_in,
    output logic       bg_rd_en_out,
    input  logic [1:0] bg_pixel_in,
    input  logic       bg_valid_in,
    output logic       spr_rd_en_out,
    input  logic [1:0] spr_pixel_in,
    input  logic       spr_palette_in,
    input  logic       spr_priority_in,
    input  logic       spr_valid_in,
    output logic [1:0] pixel_out,
    output logic       pixel_valid_out,
    output logic [7:0] X_out,
    output logic       line_done_out
);

    localparam logic [7:0] C_X_END = 8'(X_MAX);

    state_t     r_state;
    logic [2:0] r_disc;
    logic [7:0] r_x;
    logic       r_outstanding;
    logic [1:0] r_pixel;
    logic       r_pixel_valid;
    logic       r_line_done;

    logic       w_active;
    logic       w_pop;
    logic [1:0] w_bg_idx;
    logic       w_spr_win;
    logic [7:0] w_pal;
    logic [1:0] w_idx;
    logic [1:0] w_shade;
    logic [7:0] w_x_next;
    logic       w_unused;

    // Only the fine-scroll bits matter here; coarse scroll is handled by the fetcher.
    assign w_unused = ^SCX_in[7:3];

    assign w_active = (r_state == C_ST_DISCARD) || (r_state == C_ST_PUSH);

    // At most one pop in flight. A pop is suppressed on a restart cycle so the
    // fresh line never receives data requested by the line being abandoned.
    assign w_pop = tclk_in && w_active && !sprite_hit_in && !r_outstanding && !start_in;

    assign bg_rd_en_out  = w_pop;
    assign spr_rd_en_out = w_pop;

    // Sprite/background priority resolution.
    assign w_bg_idx  = bg_ena_in ? bg_pixel_in : 2'd0;
    assign w_spr_win = spr_valid_in && obj_ena_in && (spr_pixel_in != 2'd0)
                       && !(spr_priority_in && (w_bg_idx != 2'd0));
    assign w_pal     = !w_spr_win ? BGP_in : (spr_palette_in ? OBP1_in : OBP0_in);
    assign w_idx     = w_spr_win ? spr_pixel_in : w_bg_idx;

    palette_lookup u_palette_lookup (
        .i_palette (w_pal),
        .i_idx     (w_idx),
        .o_shade   (w_shade)
    );

    assign w_x_next = r_x + 8'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= C_ST_IDLE;
            r_disc        <= 3'd0;
            r_x           <= 8'd0;
            r_outstanding <= 1'b0;
            r_pixel       <= 2'd0;
            r_pixel_valid <= 1'b0;
            r_line_done   <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_line_done   <= 1'b0;
            if (start_in) begin
                r_disc        <= SCX_in[2:0];
                r_x           <= 8'd0;
                r_outstanding <= 1'b0;
                r_state       <= (SCX_in[2:0] != 3'd0) ? C_ST_DISCARD : C_ST_PUSH;
            end else begin
                // The returning pop is consumed regardless of sprite_hit_in.
                if (bg_valid_in) begin
                    r_outstanding <= 1'b0;
                end
                if (w_pop) begin
                    r_outstanding <= 1'b1;
                end
                case (r_state)
                    C_ST_IDLE: begin
                        r_state <= C_ST_IDLE;
                    end
                    C_ST_DISCARD: begin
                        if (bg_valid_in) begin
                            r_disc <= r_disc - 3'd1;
                            if (r_disc == 3'd1) begin
                                r_state <= C_ST_PUSH;
                            end
                        end
                    end
                    C_ST_PUSH: begin
                        if (bg_valid_in) begin
                            r_pixel       <= w_shade;
                            r_pixel_valid <= 1'b1;
                            r_x           <= w_x_next;
                            if (w_x_next == C_X_END) begin
                                r_state <= C_ST_DONE;
                            end
                        end
                    end
                    C_ST_DONE: begin
                        r_line_done <= 1'b1;
                        r_state     <= C_ST_IDLE;
                    end
                    default: begin
                        r_state <= C_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pixel_out       = r_pixel;
    assign pixel_valid_out = r_pixel_valid;
    assign X_out           = r_x;
    assign line_done_out   = r_line_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_mixer
// Description : Self-checking bench for pixel_mixer. A FIFO model answers
//               each pop one clk later; a scoreboard predicts every emitted
//               shade from the mixing rules and palettes in force at the
//               return cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_mixer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       tclk_in;
    logic       start_in;
    logic [7:0] SCX_in;
    logic [7:0] BGP_in;
    logic [7:0] OBP0_in;
    logic [7:0] OBP1_in;
    logic       bg_ena_in;
    logic       obj_ena_in;
    logic       sprite_hit_in;
    logic       bg_rd_en_out;
    logic [1:0] bg_pixel_in;
    logic       bg_valid_in;
    logic       spr_rd_en_out;
    logic [1:0] spr_pixel_in;
    logic       spr_palette_in;
    logic       spr_priority_in;
    logic       spr_valid_in;
    logic [1:0] pixel_out;
    logic       pixel_valid_out;
    logic [7:0] X_out;
    logic       line_done_out;

    always #5 clk_in = ~clk_in;

    pixel_mixer #(.X_MAX(160)) u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tclk_in         (tclk_in),
        .start_in        (start_in),
        .SCX_in          (SCX_in),
        .BGP_in          (BGP_in),
        .OBP0_in         (OBP0_in),
        .OBP1_in         (OBP1_in),
        .bg_ena_in       (bg_ena_in),
        .obj_ena_in      (obj_ena_in),
        .sprite_hit_in   (sprite_hit_in),
        .bg_rd_en_out    (bg_rd_en_out),
        .bg_pixel_in     (bg_pixel_in),
        .bg_valid_in     (bg_valid_in),
        .spr_rd_en_out   (spr_rd_en_out),
        .spr_pixel_in    (spr_pixel_in),
        .spr_palette_in  (spr_palette_in),
        .spr_priority_in (spr_priority_in),
        .spr_valid_in    (spr_valid_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .X_out           (X_out),
        .line_done_out   (line_done_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mixing rules written directly from the pixel priority description.
    function automatic int ref_shade(input int bgp, input int obp0, input int obp1,
                                     input int bge, input int obje, input int bgpix,
                                     input int sv, input int sp, input int spal,
                                     input int sprio);
        int  bg_idx;
        int  idx;
        int  pal;
        bit  win;
        bg_idx = (bge != 0) ? bgpix : 0;
        win    = (sv != 0) && (obje != 0) && (sp != 0) && !((sprio != 0) && (bg_idx != 0));
        pal    = win ? ((spal != 0) ? obp1 : obp0) : bgp;
        idx    = win ? sp : bg_idx;
        return (pal >> (2 * idx)) & 3;
    endfunction

    // Model / stimulus state
    int exp_q[$];
    int pat, disc_n, returned, pops, spr_pops, emitted, done_cnt;
    int stall_left, stall_x, first_pix;
    int cfg_bg_ena, cfg_obj_ena, cfg_prio;
    bit ret_pending, exp_pv, start_req, stray_req, rand_tclk, rand_hit;
    bit stall_armed, stall_prev;

    task automatic step();
        int  e;
        bit  stall_now;
        @(posedge clk_in);
        #1;
        check("pixel_valid", int'(pixel_valid_out), int'(exp_pv));
        if (pixel_valid_out) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pixel", int'(pixel_out), e);
                if (emitted == 0) first_pix = int'(pixel_out);
            end
            emitted++;
        end
        if (line_done_out) done_cnt++;

        exp_pv    = 1'b0;
        start_in  = start_req;
        start_req = 1'b0;
        tclk_in   = rand_tclk ? 1'($urandom_range(0, 1)) : 1'b1;
        bg_valid_in  = 1'b0;
        spr_valid_in = 1'b0;
        if (pat == 2) begin
            BGP_in     = 8'($urandom_range(0, 255));
            OBP0_in    = 8'($urandom_range(0, 255));
            OBP1_in    = 8'($urandom_range(0, 255));
            bg_ena_in  = 1'($urandom_range(0, 1));
            obj_ena_in = 1'($urandom_range(0, 1));
        end
        if (ret_pending || stray_req) begin
            bg_valid_in = 1'b1;
            case (pat)
                0: begin
                    bg_pixel_in     = 2'((returned % 3) + 1);
                    spr_pixel_in    = 2'd0;
                    spr_palette_in  = 1'b0;
                    spr_priority_in = 1'b0;
                    spr_valid_in    = 1'b0;
                end
                1: begin
                    bg_pixel_in     = 2'd3;
                    spr_pixel_in    = 2'd2;
                    spr_palette_in  = 1'b1;
                    spr_priority_in = 1'(cfg_prio);
                    spr_valid_in    = 1'b1;
                end
                default: begin
                    bg_pixel_in     = 2'($urandom_range(0, 3));
                    spr_pixel_in    = 2'($urandom_range(0, 3));
                    spr_palette_in  = 1'($urandom_range(0, 1));
                    spr_priority_in = 1'($urandom_range(0, 1));
                    spr_valid_in    = 1'($urandom_range(0, 1));
                end
            endcase
            if (ret_pending) begin
                if (returned >= disc_n) begin
                    exp_q.push_back(ref_shade(int'(BGP_in), int'(OBP0_in), int'(OBP1_in),
                                              int'(bg_ena_in), int'(obj_ena_in), int'(bg_pixel_in),
                                              int'(spr_valid_in), int'(spr_pixel_in),
                                              int'(spr_palette_in), int'(spr_priority_in)));
                    exp_pv = 1'b1;
                end
                returned++;
                if (stall_armed && int'(X_out) == stall_x) begin
                    stall_left  = 12;
                    stall_armed = 1'b0;
                end
            end
        end
        stray_req = 1'b0;

        stall_now     = (stall_left > 0);
        sprite_hit_in = stall_now || (rand_hit && $urandom_range(0, 7) == 0);
        if (stall_now && tclk_in) stall_left--;
        if (stall_prev && !stall_now) check("x_resume", int'(X_out), stall_x + 1);
        stall_prev = stall_now;

        #1;
        if (bg_rd_en_out)
            check("pop_qualified", int'({tclk_in, ~sprite_hit_in, ~bg_valid_in, ~start_in}), 15);
        if (sprite_hit_in) check("stall_no_pop", int'(bg_rd_en_out), 0);
        ret_pending = bg_rd_en_out;
        pops     += int'(bg_rd_en_out);
        spr_pops += int'(spr_rd_en_out);
    endtask

    task automatic abort_line();
        rst_in = 1'b1;
        #1;
        check("abort_rst_x", int'(X_out), 0);
        check("abort_rst_pv", int'(pixel_valid_out), 0);
        check("abort_rst_pop", int'(bg_rd_en_out), 0);
        check("abort_rst_pix", int'(pixel_out), 0);
        ret_pending = 1'b0;
        exp_pv      = 1'b0;
        exp_q.delete();
        done_cnt    = 0;
        pops        = 0;
        stall_left  = 0;
        stall_prev  = 1'b0;
        repeat (2) step();
        rst_in = 1'b0;
        repeat (8) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_pop", pops, 0);
    endtask

    task automatic run_line(input int scx, input int p, input int sx, input int ax,
                            input bit rt, input bit rh, input int exp_first);
        pat         = p;
        stall_x     = sx;
        stall_armed = (sx >= 0);
        stall_prev  = 1'b0;
        rand_tclk   = rt;
        rand_hit    = rh;
        SCX_in      = 8'(scx);
        disc_n      = scx & 7;
        if (p != 2) begin
            BGP_in     = 8'hE4;
            OBP0_in    = 8'h00;
            OBP1_in    = 8'h1B;
            bg_ena_in  = 1'(cfg_bg_ena);
            obj_ena_in = 1'(cfg_obj_ena);
        end
        returned   = 0;
        pops       = 0;
        spr_pops   = 0;
        emitted    = 0;
        done_cnt   = 0;
        first_pix  = -1;
        stall_left = 0;
        exp_q.delete();
        start_req  = 1'b1;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            step();
            if (ax >= 0 && int'(X_out) == ax) begin
                abort_line();
                return;
            end
        end
        step();
        stray_req = 1'b1;
        step();
        repeat (4) step();
        check("line_done_count", done_cnt, 1);
        check("pixel_count", emitted, 160);
        check("x_final", int'(X_out), 160);
        check("pop_count", pops, 160 + disc_n);
        check("spr_pop_count", spr_pops, 160 + disc_n);
        check("queue_drained", exp_q.size(), 0);
        if (exp_first >= 0) check("first_pixel", first_pix, exp_first);
    endtask

    initial begin
        rst_in = 1'b1;
        start_in = 1'b0; tclk_in = 1'b0; SCX_in = 8'd0;
        BGP_in = 8'hE4; OBP0_in = 8'h00; OBP1_in = 8'h1B;
        bg_ena_in = 1'b1; obj_ena_in = 1'b1; sprite_hit_in = 1'b0;
        bg_pixel_in = 2'd0; bg_valid_in = 1'b0;
        spr_pixel_in = 2'd0; spr_palette_in = 1'b0; spr_priority_in = 1'b0; spr_valid_in = 1'b0;
        ret_pending = 1'b0; exp_pv = 1'b0; start_req = 1'b0; stray_req = 1'b0;
        rand_tclk = 1'b0; rand_hit = 1'b0; stall_armed = 1'b0; stall_prev = 1'b0;
        stall_left = 0; stall_x = -1; pat = 0; disc_n = 0;
        cfg_bg_ena = 1; cfg_obj_ena = 1; cfg_prio = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_x", int'(X_out), 0);
        check("reset_pix", int'(pixel_out), 0);
        check("reset_pv", int'(pixel_valid_out), 0);
        check("reset_done", int'(line_done_out), 0);
        check("reset_pop", int'(bg_rd_en_out), 0);
        rst_in = 1'b0;

        // SCX=0, cycling indices 1..3 through BGP=E4
        run_line(0, 0, -1, -1, 1'b0, 1'b0, 1);
        // SCX=5: pops 0..4 discarded, pop 5 carries index 3
        run_line(5, 0, -1, -1, 1'b1, 1'b0, 3);
        // Sprite over BG via OBP1, then BG-over-OBJ priority
        cfg_prio = 0;
        run_line(0, 1, -1, -1, 1'b1, 1'b0, 1);
        cfg_prio = 1;
        run_line(0, 1, -1, -1, 1'b1, 1'b0, 3);
        // 12-tclk sprite stall at X=40 with a pop in flight
        run_line(0, 0, 40, -1, 1'b1, 1'b0, -1);
        // Reset at X=80 aborts the line, then a complete line
        run_line(3, 0, -1, 80, 1'b1, 1'b0, -1);
        run_line(2, 0, -1, -1, 1'b1, 1'b0, -1);
        // Both layers disabled: everything maps to BGP index 0
        cfg_bg_ena = 0; cfg_obj_ena = 0;
        run_line(0, 3, -1, -1, 1'b1, 1'b0, 0);
        cfg_bg_ena = 1; cfg_obj_ena = 1;
        // Fully random lines with mid-line palette changes and random stalls
        for (int k = 0; k < 4; k++) begin
            run_line(int'($urandom_range(0, 255)), 2, -1, -1, 1'b1, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_mixer.md
PIXEL_MIXER -- requirements
Module: pixel_mixer

Interface
REQ-001 Parameter X_MAX, default 160: visible pixels per scanline.
REQ-002 clk_in  input  1  system clock; the only clock.
REQ-003 rst_in  input  1  reset; asynchronous, active-high.
REQ-004 tclk_in  input  1  T-cycle enable, one clk_in wide.
REQ-005 start_in  input  1  one-cycle pulse at mode-3 start.
REQ-006 SCX_in  input  8  horizontal scroll register.
REQ-007 BGP_in, OBP0_in, OBP1_in  input  8 each  background and object palettes.
REQ-008 bg_ena_in, obj_ena_in  input  1 each  LCDC.0 and LCDC.1.
REQ-009 sprite_hit_in  input  1  sprite fetch in progress; stalls popping.
REQ-010 bg_rd_en_out  output  1  pop request to the background FIFO.
REQ-011 bg_pixel_in  input  2  background colour index.
REQ-012 bg_valid_in  input  1  bg_pixel_in valid; arrives one clk after the accepted pop.
REQ-013 spr_rd_en_out  output  1  pop request to the sprite FIFO; equal to bg_rd_en_out.
REQ-014 spr_pixel_in  input  2  sprite colour index; 0 means transparent.
REQ-015 spr_palette_in, spr_priority_in  input  1 each  OBP1 select and BG-over-OBJ flag.
REQ-016 spr_valid_in  input  1  sprite fields valid; qualified by bg_valid_in.
REQ-017 pixel_out  output  2  final shade for the LCD.
REQ-018 pixel_valid_out  output  1  pixel_out valid for one clk.
REQ-019 X_out  output  8  index of the next pixel to emit, 0..X_MAX.
REQ-020 line_done_out  output  1  one-clk pulse after the last pixel.

Function
REQ-021 The FSM SHALL have states IDLE, DISCARD, PUSH and DONE.
REQ-022 IDLE + start_in: latch disc = SCX_in[2:0] and clear X; go to DISCARD if disc != 0, else go to PUSH.
REQ-023 bg_rd_en_out SHALL be high for one clk when tclk_in=1, state is DISCARD or PUSH, sprite_hit_in=0, and no pop is outstanding.
REQ-024 A pop is outstanding from the clk it is issued until the clk bg_valid_in=1.
REQ-025 The returning pop SHALL be consumed even if sprite_hit_in has since risen; it is never lost or duplicated.
REQ-026 DISCARD: each bg_valid_in decrements disc and emits nothing; on reaching 0, go to PUSH.
REQ-027 PUSH: each bg_valid_in produces one output pixel. pixel_valid_out is registered and asserts on the clk after bg_valid_in (latency 1).
REQ-028 Background index: bg_idx = bg_ena_in ? bg_pixel_in : 0.
REQ-029 The sprite wins when spr_valid_in && obj_ena_in && spr_pixel_in != 0 && !(spr_priority_in && bg_idx != 0).
REQ-030 Output shade: pal[2*idx+1 : 2*idx], where pal is BGP_in, or OBP0_in/OBP1_in (per spr_palette_in) when the sprite wins.
REQ-031 X increments with each emitted pixel. When X reaches X_MAX, go to DONE; no further pops are issued.
REQ-032 DONE: pulse line_done_out for one clk, then go to IDLE.
REQ-033 start_in in any state other than IDLE SHALL restart the line: reload disc, clear X, drop the outstanding flag.
REQ-034 bg_valid_in in IDLE or DONE SHALL be ignored.
REQ-035 Palette registers are sampled combinationally at the emit clk; mid-line changes take effect on the next pixel.

Reset
REQ-036 On rst_in: state IDLE, X_out=0, disc=0, outstanding=0.
REQ-037 On rst_in: pixel_out=0, pixel_valid_out=0, line_done_out=0, bg_rd_en_out=0.
REQ-038 Reset asserted mid-line SHALL abort the line with no line_done_out pulse.

Structure
REQ-039 The shared ppu package SHALL hold the FSM state enum, X_MAX, and the palette-lookup function.
REQ-040 One sub-module, palette_lookup (combinational: 8-bit palette + 2-bit index -> 2-bit shade), SHALL be instantiated for the output path.

Verification
REQ-041 SCX=0, BGP=0xE4, BG FIFO model returns index 1..3 cycling -> 160 pixel_valid_out pulses with shades 1,2,3; line_done_out once; X_out=160.
REQ-042 SCX=5 -> first 5 pops produce no output; the sixth pop yields pixel X=0; total pops = 165.
REQ-043 spr_pixel=2, OBP1=0x1B, spr_palette=1, priority=0, bg_idx=3 -> shade 1. Same stimulus with priority=1 -> BGP shade for index 3.
REQ-044 sprite_hit_in raised for 12 tclk at X=40, with a pop outstanding -> that pixel is emitted, no pops during the stall, X resumes at 41, no duplicate pixels.
REQ-045 rst_in asserted at X=80, then start_in -> no line_done_out for the aborted line; the new line emits a full 160 pixels.
REQ-046 bg_ena_in=0, obj_ena_in=0, BGP=0xE4 -> all 160 pixels shade 0.
